// File: rtl/vram_pkg.sv
// +-------------------------------------------------------------------------+
// | vram_pkg : shared types, default geometry and address helper for the   |
// |            frame-buffer arbiter                                         |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

package vram_pkg;

  localparam int c_FB_W   = 320;
  localparam int c_FB_H   = 240;
  localparam int c_ADDR_W = 17;

  typedef logic [11:0] rgb12;

  typedef struct packed {
    logic [c_ADDR_W-1:0] addr;
    rgb12                data;
  } wr_entry_t;

  // Row-major linear address; callers truncate to their RAM address width.
  function automatic int unsigned fb_addr(input int unsigned x,
                                          input int unsigned y,
                                          input int unsigned w = c_FB_W);
    return y * w + x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wr_fifo.sv
// +-------------------------------------------------------------------------+
// | wr_fifo  : in-order synchronous FIFO of pending frame-buffer writes     |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

module wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  wr_entry_t push_data,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int c_PTR_W = $clog2(DEPTH);

  wr_entry_t          r_mem [DEPTH];
  logic [c_PTR_W:0]   r_wptr;
  logic [c_PTR_W:0]   r_rptr;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                 (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
  assign head  = r_mem[r_rptr[c_PTR_W-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[c_PTR_W-1:0]] <= push_data;
        r_wptr                     <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// +-------------------------------------------------------------------------+
// | vram_arbiter : shares one single-port frame-buffer RAM between display  |
// |                scan-out (always wins) and a FIFO-buffered pixel writer. |
// |                Optional fill-clear engine: VRAM_ARBITER_CLEAR_EN        |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
`default_nettype none

module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FB_W     = c_FB_W,
  parameter int FB_H     = c_FB_H,
  parameter int SCALE_SH = 1,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int WF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic [11:0]       pixel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [11:0]       wr_data,
  output logic [7:0]        drop_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata
`ifdef VRAM_ARBITER_CLEAR_EN
  ,
  input  logic              clr_req,
  input  logic [11:0]       clr_color,
  output logic              clr_busy
`endif
);

  logic              w_disp_req;
  logic              w_disp_slot;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_in_range;
  logic              w_accept;
  wr_entry_t         w_push_entry;
  wr_entry_t         w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_clr_active;
  logic              w_clr_write;
  logic [ADDR_W-1:0] w_clr_addr;
  rgb12              w_clr_data;
  logic              r_rd_d1;
  logic              r_req_d1;
  rgb12              r_hold;
  logic [7:0]        r_drop_cnt;

  // Display requests are masked during reset so the RAM port idles at 0.
  assign w_disp_req = rstn && (pix_x != 10'h3FF) && (pix_y != 10'h3FF);

  generate
    if (SCALE_SH > 0) begin : g_slot_scaled
      assign w_disp_slot = w_disp_req && (pix_x[SCALE_SH-1:0] == '0);
    end else begin : g_slot_every
      assign w_disp_slot = w_disp_req;
    end
  endgenerate

  assign w_disp_addr = ADDR_W'(fb_addr(32'(pix_x >> SCALE_SH),
                                       32'(pix_y >> SCALE_SH), FB_W));

  assign w_in_range = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
  assign wr_ready   = rstn && !w_fifo_full && !w_clr_active;
  assign w_accept   = wr_valid && wr_ready;

  assign w_push_entry.addr = c_ADDR_W'(fb_addr(32'(wr_x), 32'(wr_y), FB_W));
  assign w_push_entry.data = wr_data;

  wr_fifo #(
    .DEPTH (WF_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_accept && w_in_range),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

`ifdef VRAM_ARBITER_CLEAR_EN
  localparam int c_FB_LAST = FB_W * FB_H - 1;

  logic              r_clr_busy;
  logic [ADDR_W-1:0] r_clr_addr;
  rgb12              r_clr_color;

  assign w_clr_active = r_clr_busy;
  assign w_clr_write  = r_clr_busy && !w_disp_slot;
  assign w_clr_addr   = r_clr_addr;
  assign w_clr_data   = r_clr_color;
  assign clr_busy     = r_clr_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clr_busy  <= 1'b0;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else if (!r_clr_busy) begin
      if (clr_req) begin
        r_clr_busy  <= 1'b1;
        r_clr_addr  <= '0;
        r_clr_color <= clr_color;
      end
    end else if (w_clr_write) begin
      if (r_clr_addr == ADDR_W'(c_FB_LAST)) begin
        r_clr_busy <= 1'b0;
      end else begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end
`else
  assign w_clr_active = 1'b0;
  assign w_clr_write  = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_data   = '0;
`endif

  // Slot arbitration: display read, then clear fill, then FIFO drain.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_pop     = 1'b0;
    if (w_disp_slot) begin
      mem_addr = w_disp_addr;
    end else if (w_clr_write) begin
      mem_we    = 1'b1;
      mem_addr  = w_clr_addr;
      mem_wdata = w_clr_data;
    end else if (!w_fifo_empty) begin
      w_pop     = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(w_head.addr);
      mem_wdata = w_head.data;
    end
  end

  assign pixel = r_req_d1 ? (r_rd_d1 ? mem_rdata : r_hold) : 12'h000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_d1    <= 1'b0;
      r_req_d1   <= 1'b0;
      r_hold     <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_rd_d1  <= w_disp_slot;
      r_req_d1 <= w_disp_req;
      r_hold   <= pixel;
      if (w_accept && !w_in_range && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// +-------------------------------------------------------------------------+
// | tb_vram_arbiter : directed self-checking bench with a behavioural RAM   |
// | Revision        : 1.0                                                   |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_vram_arbiter;

  logic        clk;
  logic        rstn;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pixel;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [11:0] wr_data;
  logic [7:0]  drop_cnt;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
`ifdef VRAM_ARBITER_CLEAR_EN
  logic        clr_req;
  logic [11:0] clr_color;
  logic        clr_busy;
`endif

  logic [11:0] ram [0:131071];
  int          errors;
  int          checks;

  vram_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pixel     (pixel),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .drop_cnt  (drop_cnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef VRAM_ARBITER_CLEAR_EN
    ,
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .clr_busy  (clr_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix_x    = 10'h3FF;
    pix_y    = 10'h3FF;
    wr_valid = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_data  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #12;
    checks++; if (pixel !== 12'h000) begin errors++; $display("FAIL rst_pixel: got %h want 000", pixel); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", wr_ready); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 17'd0 || mem_wdata !== 12'h000) begin
      errors++; $display("FAIL rst_mem: we=%b addr=%0d wdata=%h want 0/0/000", mem_we, mem_addr, mem_wdata); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    tick(); tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", wr_ready); end
    checks++; if (pixel !== 12'h000 || mem_we !== 1'b0) begin
      errors++; $display("FAIL idle_out: pixel=%h we=%b want 000/0", pixel, mem_we); end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1; wr_x = 10'd5; wr_y = 9'd3; wr_data = 12'hF0F;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 17'd965 || mem_wdata !== 12'hF0F) begin
      errors++; $display("FAIL sw_write: we=%b addr=%0d data=%h want 1/965/F0F", mem_we, mem_addr, mem_wdata); end
    tick();
    pix_x = 10'd10; pix_y = 10'd6;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 17'd965) begin
      errors++; $display("FAIL sw_read_addr: we=%b addr=%0d want 0/965", mem_we, mem_addr); end
    tick();
    pix_x = 10'd11;
    #1;
    checks++; if (pixel !== 12'hF0F) begin errors++; $display("FAIL sw_pixel_x10: got %h want F0F", pixel); end
    tick();
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    #1;
    checks++; if (pixel !== 12'hF0F) begin errors++; $display("FAIL sw_pixel_x11: got %h want F0F", pixel); end
    tick();
    checks++; if (pixel !== 12'h000) begin errors++; $display("FAIL sw_pixel_blank: got %h want 000", pixel); end
  endtask

  task automatic test_stream();
    logic [28:0] q[$];
    int          cnt;
    int          sent;
    int          cyc;
    logic        free, pop_e, rdy_e;
    cnt = 0; sent = 0; cyc = 0;
    while (cyc < 1000 && !(sent == 100 && cnt == 0 && cyc >= 640)) begin
      pix_x    = (cyc < 640) ? 10'(cyc) : 10'h3FF;
      pix_y    = (cyc < 640) ? 10'd0 : 10'h3FF;
      wr_valid = (sent < 100);
      wr_x     = 10'(sent);
      wr_y     = 9'd100;
      wr_data  = 12'h100 + 12'(sent);
      #1;
      free  = !(cyc < 640 && (cyc % 2) == 0);
      pop_e = free && (cnt > 0);
      rdy_e = (cnt < 4);
      checks++; if (wr_ready !== rdy_e) begin
        errors++; $display("FAIL st_ready cyc=%0d: got %b want %b", cyc, wr_ready, rdy_e); end
      checks++; if (mem_we !== pop_e) begin
        errors++; $display("FAIL st_we cyc=%0d: got %b want %b", cyc, mem_we, pop_e); end
      if (pop_e) begin
        checks++; if ({mem_addr, mem_wdata} !== q[0]) begin
          errors++; $display("FAIL st_order cyc=%0d: got %0d/%h want %0d/%h",
                             cyc, mem_addr, mem_wdata, q[0][28:12], q[0][11:0]); end
        void'(q.pop_front());
        cnt--;
      end
      if (!free) begin
        checks++; if (mem_addr !== 17'(cyc / 2)) begin
          errors++; $display("FAIL st_disp_addr cyc=%0d: got %0d want %0d", cyc, mem_addr, cyc / 2); end
      end
      if (wr_valid && rdy_e) begin
        q.push_back({17'(32000 + sent), 12'h100 + 12'(sent)});
        cnt++;
        sent++;
      end
      tick();
      cyc++;
    end
    checks++; if (sent != 100 || cnt != 0) begin
      errors++; $display("FAIL st_done: sent=%0d pending=%0d want 100/0", sent, cnt); end
    idle_inputs();
    tick();
    checks++; if (ram[32099] !== 12'h163) begin
      errors++; $display("FAIL st_ram_last: got %h want 163", ram[32099]); end
  endtask

  task automatic test_drop();
    logic saw_we;
    wr_valid = 1'b1; wr_x = 10'd320; wr_y = 9'd0; wr_data = 12'hAAA;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL dr_ready: got %b want 1", wr_ready); end
    tick();
    wr_x = 10'd0; wr_y = 9'd240;
    #1;
    checks++; if (mem_we !== 1'b0 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL dr_first: we=%b drop=%0d want 0/1", mem_we, drop_cnt); end
    tick();
    wr_x = 10'd320; wr_y = 9'd0;
    #1;
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL dr_row: got %0d want 2", drop_cnt); end
    saw_we = 1'b0;
    for (int i = 0; i < 253; i++) begin
      if (mem_we) saw_we = 1'b1;
      tick();
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL dr_255: got %0d want 255", drop_cnt); end
    for (int i = 0; i < 46; i++) begin
      if (mem_we) saw_we = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    #1;
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL dr_sat: got %0d want 255", drop_cnt); end
    checks++; if (saw_we !== 1'b0) begin errors++; $display("FAIL dr_no_write: got we seen=%b want 0", saw_we); end
  endtask

  task automatic test_line_edges();
    wr_valid = 1'b1; wr_x = 10'd0; wr_y = 9'd0; wr_data = 12'hABC;
    tick();
    wr_x = 10'd319; wr_data = 12'h123;
    tick();
    wr_valid = 1'b0;
    tick(); tick();
    pix_y = 10'd0; pix_x = 10'h3FF;
    tick();
    for (int x = 0; x < 640; x++) begin
      pix_x = 10'(x);
      #1;
      if (x == 0) begin
        checks++; if (mem_addr !== 17'd0 || mem_we !== 1'b0 || pixel !== 12'h000) begin
          errors++; $display("FAIL le_start: addr=%0d we=%b pixel=%h want 0/0/000", mem_addr, mem_we, pixel); end
      end
      if (x == 1 || x == 2) begin
        checks++; if (pixel !== 12'hABC) begin errors++; $display("FAIL le_first_px x=%0d: got %h want ABC", x, pixel); end
      end
      if (x == 638) begin
        checks++; if (mem_addr !== 17'd319) begin errors++; $display("FAIL le_end_addr: got %0d want 319", mem_addr); end
      end
      if (x == 639) begin
        checks++; if (pixel !== 12'h123) begin errors++; $display("FAIL le_x638: got %h want 123", pixel); end
      end
      tick();
    end
    pix_x = 10'h3FF;
    #1;
    checks++; if (pixel !== 12'h123) begin errors++; $display("FAIL le_x639: got %h want 123", pixel); end
    tick();
    checks++; if (pixel !== 12'h000) begin errors++; $display("FAIL le_blank: got %h want 000", pixel); end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    wr_valid = 1'b1; wr_x = 10'd7; wr_y = 9'd7; wr_data = 12'h777;
    tick();
    wr_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL mr_during: we=%b ready=%b want 0/0", mem_we, wr_ready); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++; if (mem_we !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL mr_after: we=%b drop=%0d want 0/0", mem_we, drop_cnt); end
  endtask

`ifdef VRAM_ARBITER_CLEAR_EN
  task automatic test_clear();
    int writes;
    int bad_ready;
    int cyc;
    clr_req = 1'b1; clr_color = 12'h00F;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL cl_idle: got %b want 0", clr_busy); end
    tick();
    clr_req = 1'b0;
    writes = 0; bad_ready = 0; cyc = 0;
    while (clr_busy === 1'b1 && cyc < 80000) begin
      if (wr_ready !== 1'b0) bad_ready++;
      if (mem_we === 1'b1) writes++;
      tick();
      cyc++;
    end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL cl_timeout: busy=%b want 0", clr_busy); end
    checks++; if (writes != 76800) begin errors++; $display("FAIL cl_writes: got %0d want 76800", writes); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL cl_ready: ready high %0d cycles want 0", bad_ready); end
    checks++; if (ram[0] !== 12'h00F || ram[76799] !== 12'h00F) begin
      errors++; $display("FAIL cl_ram: got %h/%h want 00F/00F", ram[0], ram[76799]); end
    pix_x = 10'd0; pix_y = 10'd0;
    tick();
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    #1;
    checks++; if (pixel !== 12'h00F) begin errors++; $display("FAIL cl_readback: got %h want 00F", pixel); end
    tick();
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 131072; i++) ram[i] = 12'h000;
`ifdef VRAM_ARBITER_CLEAR_EN
    clr_req   = 1'b0;
    clr_color = 12'h000;
`endif
    test_reset();
    test_single_write();
    test_stream();
    test_drop();
    test_line_edges();
    test_mid_reset();
`ifdef VRAM_ARBITER_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between display scan-out and a pixel writer (game/draw logic).
- Display reads are driven by the timing generator's pix_x/pix_y (10'h3FF outside active video). Results go back on pixel[11:0].
- Frame buffer is FB_W x FB_H at 12-bit RGB, upscaled by pixel replication. Writer traffic uses the slots the display does not need.

Parameters:
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- SCALE_SH, 1, upscale shift; display pixel (x,y) maps to FB (x>>SCALE_SH, y>>SCALE_SH)
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H
- WF_DEPTH, 4, write-FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- pix_x  in  10  display column request, 10'h3FF = no request
- pix_y  in  10  display row request, 10'h3FF = no request
- pixel  out  12  RGB for the coordinate presented one clock earlier
- wr_valid  in  1  writer request
- wr_ready  out  1  writer accepted when wr_valid && wr_ready
- wr_x  in  10  FB column
- wr_y  in  9  FB row
- wr_data  in  12  RGB to write
- drop_cnt  out  8  saturating count of out-of-range writes
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  12  RAM write data
- mem_rdata  in  12  RAM read data, valid 1 clk after a read address

Behaviour:
- Reset values:
  - pixel=0, wr_ready=0 during reset then FIFO-not-full.
  - drop_cnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - FIFO empty, all internal registers 0.
- disp_req is true when pix_x != 10'h3FF && pix_y != 10'h3FF.
- disp_slot is true when disp_req && pix_x[SCALE_SH-1:0]==0. With SCALE_SH=0, every disp_req cycle is a display slot.
- Display slot: mem_addr = (pix_y>>SCALE_SH)*FB_W + (pix_x>>SCALE_SH), mem_we=0. The display always wins; there is no writer preemption.
- Any other cycle is a free slot. If the FIFO is non-empty, pop the head: mem_we=1, mem_addr=head address, mem_wdata=head data. Otherwise mem_we=0.
- Pixel path:
  - rd_d1 = disp_slot delayed 1 clk; req_d1 = disp_req delayed 1 clk.
  - pixel = req_d1 ? (rd_d1 ? mem_rdata : hold) : 12'h000.
  - hold <= pixel every clock.
  - Latency is exactly 1 clk from coordinate to pixel; the display path absorbs the one-column shift.
  - Replicated columns reuse hold, so RAM read-during-write mode is irrelevant.
- Writer handshake:
  - wr_ready = !fifo_full; it does not depend on a same-cycle pop.
  - On accept, the address is computed and pushed if wr_x<FB_W && wr_y<FB_H.
  - Otherwise the write is accepted, discarded, and drop_cnt increments, saturating at 8'hFF.
- FIFO is in order. Simultaneous push and pop when non-empty keeps the count unchanged.
- Ordering: a write accepted at cycle t is visible to display reads issued no earlier than the cycle after its pop.
- Starvation bound:
  - With SCALE_SH>=1, at least 1 free slot occurs every 2^SCALE_SH clks during active video.
  - All cycles are free during blanking.
- Mid-operation reset: FIFO contents are lost, mem_we drops immediately, and no partial write is issued.

Optional Feature:
- Macro: VRAM_ARBITER_CLEAR_EN.
- When defined, three ports are added: clr_req in 1 (pulse), clr_color in 12, clr_busy out 1. Behaviour:
  - A clr_req while idle sets clr_busy and captures clr_color.
  - A counter walks addresses 0..FB_W*FB_H-1, writing one per free slot. Clear has priority over the FIFO; wr_ready=0 while busy.
  - clr_busy falls the cycle after the last address is written.
  - clr_req while busy is ignored. Reset aborts the clear.
- When undefined, these ports and the logic are absent.

Decomposition:
- vram_pkg holds:
  - FB_W, FB_H, ADDR_W defaults
  - rgb12 typedef
  - fb_addr(x,y) function
  - the write-entry struct {addr, data}
- One sub-module, wr_fifo: synchronous FIFO with full/empty and push/pop, holding write entries.

Test Plan:
- Reset, then idle: pixel=0, mem_we=0, wr_ready=1, drop_cnt=0.
- Write (5,3)=12'hF0F during blanking → next clk mem_we=1, mem_addr=965, mem_wdata=12'hF0F. Then display pix_x=10,11, pix_y=6 → pixel=12'hF0F on both following clks.
- Writer streams 100 writes continuously during an active line (SCALE_SH=1) → writes occur only on odd pix_x, order preserved, and wr_ready toggles only on full with depth 4.
- Write wr_x=320, wr_y=0 → accepted with no RAM write, drop_cnt=1. Repeat 300 times → drop_cnt=255.
- Line start/end: pix_x 3FF→0 → mem_addr valid at pix_x=0, pixel nonzero 1 clk later. pix_x 639→3FF → pixel=0 the cycle after.
- VRAM_ARBITER_CLEAR_EN: clr_req with 12'h00F during blanking:
  - clr_busy holds until 76800 writes complete.
  - wr_ready=0 throughout.
  - Readback of address 0 and 76799 gives 12'h00F.
